// File: rtl/rtmc_pkg.sv
// rtl/rtmc_pkg.sv - shared types for the step/direction pulse generator
package rtmc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } step_state_e;

    localparam int MAX_NCH = 8;

endpackage

// File: rtl/rtmc_step_chan.sv
// rtl/rtmc_step_chan.sv - one step/direction channel: phase FSM, step countdown, signed position
module rtmc_step_chan
    import rtmc_pkg::*;
#(
    parameter int COUNT_W      = 16,
    parameter int PERIOD_W     = 16,
    parameter int POS_W        = 24,
    parameter int PULSE_CYCLES = 4,
    parameter int DIR_SETUP    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic                dir_i,
    input  logic [COUNT_W-1:0]  steps_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic                abort_i,
    output logic                ready_o,
    output logic                step_o,
    output logic                dir_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [POS_W-1:0]    pos_o
);

    localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_CYCLES);
    localparam logic [PERIOD_W-1:0] PULSE_LEN  = PERIOD_W'(PULSE_CYCLES);
    localparam logic [PERIOD_W-1:0] SETUP_LEN  = PERIOD_W'(DIR_SETUP);
    localparam logic [PERIOD_W-1:0] TMR_ONE    = PERIOD_W'(1);

    step_state_e         state_q, state_d;
    logic [PERIOD_W-1:0] tmr_q, tmr_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [COUNT_W-1:0]  rem_q, rem_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                dir_q, dir_d;
    logic                step_q, step_d;
    logic                done_q, done_d;
    logic                abort_pend_q, abort_pend_d;
    logic                go_high;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            period_q     <= '0;
            rem_q        <= '0;
            pos_q        <= '0;
            dir_q        <= 1'b0;
            step_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            period_q     <= period_d;
            rem_q        <= rem_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            step_q       <= step_d;
            done_q       <= done_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        period_d     = period_q;
        rem_d        = rem_q;
        pos_d        = pos_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        abort_pend_d = abort_pend_q;
        go_high      = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    if (steps_i != '0) begin
                        state_d      = SETUP;
                        dir_d        = dir_i;
                        rem_d        = steps_i;
                        period_d     = (period_i < MIN_PERIOD) ? MIN_PERIOD : period_i;
                        tmr_d        = SETUP_LEN - TMR_ONE;
                        abort_pend_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETUP, LOW: begin
                if (abort_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tmr_q == '0) begin
                    go_high = 1'b1;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            HIGH: begin
                // An abort seen during the pulse is remembered so the pulse is never cut short.
                abort_pend_d = abort_pend_q | abort_i;
                if (tmr_q == '0) begin
                    if (rem_q == '0 || abort_pend_q || abort_i) begin
                        state_d      = IDLE;
                        done_d       = 1'b1;
                        abort_pend_d = 1'b0;
                    end else begin
                        state_d = LOW;
                        tmr_d   = period_q - PULSE_LEN - TMR_ONE;
                    end
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_high) begin
            state_d = HIGH;
            tmr_d   = PULSE_LEN - TMR_ONE;
            rem_d   = rem_q - COUNT_W'(1);
            pos_d   = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
        end

        step_d = (state_d == HIGH);
    end

    assign ready_o = (state_q == IDLE) && !abort_i;
    assign step_o  = step_q;
    assign dir_o   = dir_q;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign pos_o   = pos_q;

endmodule

// File: rtl/rtmc_step_gen.sv
// rtl/rtmc_step_gen.sv - NCH independent step/direction channels behind one command handshake
module rtmc_step_gen
    import rtmc_pkg::*;
#(
    parameter int NCH          = 4,
    parameter int COUNT_W      = 16,
    parameter int PERIOD_W     = 16,
    parameter int POS_W        = 24,
    parameter int PULSE_CYCLES = 4,
    parameter int DIR_SETUP    = 2,
    localparam int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CH_W-1:0]      cmd_ch,
    input  logic                 cmd_dir,
    input  logic [COUNT_W-1:0]   cmd_steps,
    input  logic [PERIOD_W-1:0]  cmd_period,
    input  logic [NCH-1:0]       abort,
    output logic [NCH-1:0]       step,
    output logic [NCH-1:0]       dir,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH*POS_W-1:0] pos
);

    logic [NCH-1:0]         ready_vec;
    logic [(1<<CH_W)-1:0]   ready_pad;

    // Unpopulated channel codes read as never ready.
    always_comb begin
        ready_pad            = '0;
        ready_pad[NCH-1:0]   = ready_vec;
    end

    assign cmd_ready = ready_pad[cmd_ch];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic load;
        assign load = cmd_valid && cmd_ready && (cmd_ch == CH_W'(i));

        rtmc_step_chan #(
            .COUNT_W      (COUNT_W),
            .PERIOD_W     (PERIOD_W),
            .POS_W        (POS_W),
            .PULSE_CYCLES (PULSE_CYCLES),
            .DIR_SETUP    (DIR_SETUP)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load),
            .dir_i    (cmd_dir),
            .steps_i  (cmd_steps),
            .period_i (cmd_period),
            .abort_i  (abort[i]),
            .ready_o  (ready_vec[i]),
            .step_o   (step[i]),
            .dir_o    (dir[i]),
            .busy_o   (busy[i]),
            .done_o   (done[i]),
            .pos_o    (pos[i*POS_W +: POS_W])
        );
    end

endmodule

// File: tb/tb_rtmc_step_gen.sv
// tb/tb_rtmc_step_gen.sv - self-checking bench for rtmc_step_gen
module tb_rtmc_step_gen;

    localparam int NCH   = 4;
    localparam int POS_W = 24;
    localparam int PW    = 4;
    localparam int DS    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_ch = '0;
    logic                 cmd_dir = 1'b0;
    logic [15:0]          cmd_steps = '0;
    logic [15:0]          cmd_period = '0;
    logic [NCH-1:0]       abort = '0;
    logic [NCH-1:0]       step, dir, busy, done;
    logic [NCH*POS_W-1:0] pos;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int acc [NCH];
    int mn  [NCH];
    int mp  [NCH];
    bit md  [NCH];
    bit mdir[NCH];
    int base[NCH];

    rtmc_step_gen #(
        .NCH(NCH), .COUNT_W(16), .PERIOD_W(16), .POS_W(POS_W),
        .PULSE_CYCLES(PW), .DIR_SETUP(DS)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
        .cmd_period(cmd_period), .abort(abort), .step(step), .dir(dir),
        .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int eff(int p);
        return (p < 2 * PW) ? 2 * PW : p;
    endfunction

    function automatic int m_rises(int k, int n, int p);
        int r;
        if (n == 0 || k < 1 + DS) return 0;
        r = (k - 1 - DS) / p + 1;
        return (r > n) ? n : r;
    endfunction

    function automatic bit m_step(int k, int n, int p);
        if (n == 0 || k < 1 + DS) return 1'b0;
        return ((k - 1 - DS) / p < n) && ((k - 1 - DS) % p < PW);
    endfunction

    function automatic int m_end(int n, int p);
        return (n == 0) ? 1 : 1 + DS + (n - 1) * p + PW;
    endfunction

    function automatic bit m_busy(int k, int n, int p);
        return (n > 0) && (k >= 1) && (k < m_end(n, p));
    endfunction

    function automatic bit m_done(int k, int n, int p);
        return k == m_end(n, p);
    endfunction

    function automatic logic [POS_W-1:0] m_pos(int ch, int c);
        int r;
        r = m_rises(c - acc[ch], mn[ch], mp[ch]);
        return POS_W'(md[ch] ? base[ch] + r : base[ch] - r);
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            acc[ch] = -1000; mn[ch] = 0; mp[ch] = 2 * PW;
            md[ch] = 1'b0; mdir[ch] = 1'b0; base[ch] = 0;
        end
    endtask

    task automatic model_accept(int ch, bit d, int n, int p, int c);
        int r;
        r = m_rises(c - acc[ch], mn[ch], mp[ch]);
        base[ch] = md[ch] ? base[ch] + r : base[ch] - r;
        acc[ch] = c; mn[ch] = n; mp[ch] = eff(p); md[ch] = d;
        if (n > 0) mdir[ch] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cmd_valid = 1'b0; abort = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic set_cmd(int ch, bit d, int n, int p);
        cmd_valid  = 1'b1;
        cmd_ch     = 2'(ch);
        cmd_dir    = d;
        cmd_steps  = 16'(n);
        cmd_period = 16'(p);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (step !== '0 || busy !== '0 || done !== '0 || dir !== '0 || pos !== '0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: step=%b busy=%b done=%b dir=%b pos=%h ready=%b, expected all zero and ready=1",
                     step, busy, done, dir, pos, cmd_ready);
        end
    endtask

    task automatic test_single();
        logic [POS_W-1:0] ep;
        bit es, ed, eb;
        do_reset();
        @(negedge clk);
        set_cmd(1, 1'b1, 3, 10);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", cmd_ready);
        end
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            es = (k >= 3 && k <= 6) || (k >= 13 && k <= 16) || (k >= 23 && k <= 26);
            ep = (k >= 23) ? 24'd3 : (k >= 13) ? 24'd2 : (k >= 3) ? 24'd1 : 24'd0;
            ed = (k == 27);
            eb = (k >= 1 && k < 27);
            n_checks++;
            if (step[1] !== es || pos[POS_W +: POS_W] !== ep || done[1] !== ed || busy[1] !== eb
                || dir[1] !== (k >= 1) || (step & 4'b1101) !== 4'b0000) begin
                n_fail++;
                $display("FAIL single k=%0d step/pos/done/busy/dir got %b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
                         k, step[1], pos[POS_W +: POS_W], done[1], busy[1], dir[1], es, ep, ed, eb, (k >= 1));
            end
        end
    endtask

    task automatic test_clamp();
        bit es, ed;
        logic [POS_W-1:0] ep;
        do_reset();
        @(negedge clk);
        set_cmd(0, 1'b1, 2, 5);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            es = (k >= 3 && k <= 6) || (k >= 11 && k <= 14);
            ed = (k == 15);
            ep = (k >= 11) ? 24'd2 : (k >= 3) ? 24'd1 : 24'd0;
            n_checks++;
            if (step[0] !== es || done[0] !== ed || pos[0 +: POS_W] !== ep) begin
                n_fail++;
                $display("FAIL clamp k=%0d step/done/pos got %b/%b/%0d expected %b/%b/%0d",
                         k, step[0], done[0], pos[0 +: POS_W], es, ed, ep);
            end
        end
    endtask

    task automatic test_zero();
        do_reset();
        @(negedge clk);
        set_cmd(2, 1'b1, 0, 10);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_ready: got %b expected 1", cmd_ready);
        end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            n_checks++;
            if (done[2] !== (k == 1) || busy[2] !== 1'b0 || step[2] !== 1'b0 || dir[2] !== 1'b0
                || pos[2*POS_W +: POS_W] !== '0) begin
                n_fail++;
                $display("FAIL zero k=%0d done/busy/step/dir/pos got %b/%b/%b/%b/%0d expected %b/0/0/0/0",
                         k, done[2], busy[2], step[2], dir[2], pos[2*POS_W +: POS_W], (k == 1));
            end
        end
    endtask

    task automatic test_abort();
        bit es, ed, eb;
        logic [POS_W-1:0] ep;
        do_reset();
        @(negedge clk);
        set_cmd(0, 1'b0, 5, 10);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            es = (k >= 3 && k <= 6);
            ed = (k == 7);
            eb = (k >= 1 && k < 7);
            ep = (k >= 3) ? 24'hFFFFFF : 24'h0;
            n_checks++;
            if (step[0] !== es || done[0] !== ed || busy[0] !== eb || pos[0 +: POS_W] !== ep) begin
                n_fail++;
                $display("FAIL abort_high k=%0d step/done/busy/pos got %b/%b/%b/%h expected %b/%b/%b/%h",
                         k, step[0], done[0], busy[0], pos[0 +: POS_W], es, ed, eb, ep);
            end
            if (k == 4) abort[0] = 1'b1;
            if (k == 5) abort[0] = 1'b0;
        end
        @(negedge clk);
        abort[0] = 1'b1;
        set_cmd(0, 1'b0, 3, 10);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle_ready: got %b expected 0", cmd_ready);
        end
        abort[0] = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_release_ready: got %b expected 1", cmd_ready);
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            es = (k >= 3 && k <= 6);
            ed = (k == 9);
            eb = (k >= 1 && k < 9);
            ep = (k >= 3) ? 24'hFFFFFE : 24'hFFFFFF;
            n_checks++;
            if (step[0] !== es || done[0] !== ed || busy[0] !== eb || pos[0 +: POS_W] !== ep) begin
                n_fail++;
                $display("FAIL abort_low k=%0d step/done/busy/pos got %b/%b/%b/%h expected %b/%b/%b/%h",
                         k, step[0], done[0], busy[0], pos[0 +: POS_W], es, ed, eb, ep);
            end
            if (k == 8) abort[0] = 1'b1;
            if (k == 9) abort[0] = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        set_cmd(0, 1'b1, 2, 10);
        model_accept(0, 1'b1, 2, 10, cyc);
        repeat (2) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        set_cmd(0, 1'b0, 3, 9);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_ready: got %b expected 0", cmd_ready);
        end
        cmd_ch = 2'd3;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_other_ready: got %b expected 1", cmd_ready);
        end
        model_accept(3, 1'b0, 3, 9, cyc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                int k;
                k = cyc - acc[ch];
                n_checks++;
                if (step[ch] !== m_step(k, mn[ch], mp[ch]) || busy[ch] !== m_busy(k, mn[ch], mp[ch])
                    || done[ch] !== m_done(k, mn[ch], mp[ch]) || dir[ch] !== mdir[ch]
                    || pos[ch*POS_W +: POS_W] !== m_pos(ch, cyc)) begin
                    n_fail++;
                    $display("FAIL b2b ch%0d k=%0d step/busy/done/dir/pos got %b%b%b%b %h expected %b%b%b%b %h",
                             ch, k, step[ch], busy[ch], done[ch], dir[ch], pos[ch*POS_W +: POS_W],
                             m_step(k, mn[ch], mp[ch]), m_busy(k, mn[ch], mp[ch]),
                             m_done(k, mn[ch], mp[ch]), mdir[ch], m_pos(ch, cyc));
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                int k;
                k = cyc - acc[ch];
                n_checks++;
                if (step[ch] !== m_step(k, mn[ch], mp[ch]) || busy[ch] !== m_busy(k, mn[ch], mp[ch])
                    || done[ch] !== m_done(k, mn[ch], mp[ch]) || dir[ch] !== mdir[ch]
                    || pos[ch*POS_W +: POS_W] !== m_pos(ch, cyc)) begin
                    n_fail++;
                    $display("FAIL rand ch%0d k=%0d step/busy/done/dir/pos got %b%b%b%b %h expected %b%b%b%b %h",
                             ch, k, step[ch], busy[ch], done[ch], dir[ch], pos[ch*POS_W +: POS_W],
                             m_step(k, mn[ch], mp[ch]), m_busy(k, mn[ch], mp[ch]),
                             m_done(k, mn[ch], mp[ch]), mdir[ch], m_pos(ch, cyc));
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                int ch, n, p;
                bit d, exp_ready;
                ch = $urandom_range(0, NCH - 1);
                d  = 1'($urandom_range(0, 1));
                n  = $urandom_range(0, 3);
                p  = $urandom_range(0, 14);
                set_cmd(ch, d, n, p);
                #1;
                exp_ready = !m_busy(cyc - acc[ch], mn[ch], mp[ch]);
                n_checks++;
                if (cmd_ready !== exp_ready) begin
                    n_fail++;
                    $display("FAIL rand_ready ch%0d: got %b expected %b", ch, cmd_ready, exp_ready);
                end
                if (exp_ready) model_accept(ch, d, n, p, cyc);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        set_cmd(1, 1'b1, 5, 10);
        repeat (4) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        n_checks++;
        if (step[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: step[1] got %b expected 1", step[1]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (step !== '0 || busy !== '0 || done !== '0 || dir !== '0 || pos !== '0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: step=%b busy=%b done=%b dir=%b pos=%h ready=%b, expected all zero and ready=1",
                     step, busy, done, dir, pos, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (done !== '0 || busy !== '0) begin
                n_fail++;
                $display("FAIL reset_mid_after: done=%b busy=%b expected 0/0", done, busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_clamp();
        test_zero();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rtmc_step_gen.md
# rtmc_step_gen

Parametrised N-channel step/direction pulse generator for the real-time motor controller. It accepts per-channel move commands (direction, step count, step period) over a valid/ready handshake and produces glitch-free step pulses with direction setup time. It tracks a signed position per channel and supports per-channel abort. It sits between the SPI register file and the motor output pins, replacing fixed single-channel motor drive with `NCH` independent channels.

## Interface
- `NCH`, 4: number of channels (1–8).
- `COUNT_W`, 16: width of step count.
- `PERIOD_W`, 16: width of step period, in clk cycles.
- `POS_W`, 24: width of signed position counter.
- `PULSE_CYCLES`, 4: step high time in cycles (≥1).
- `DIR_SETUP`, 2: cycles from dir update to first step rise (≥1).

- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_ch` in `$clog2(NCH)` (min 1): target channel.
- `cmd_dir` in 1: 1 = forward (+1 per step), 0 = reverse.
- `cmd_steps` in `COUNT_W`: number of steps (0 allowed).
- `cmd_period` in `PERIOD_W`: cycles between successive step rising edges.
- `abort` in `NCH`: per-channel stop request, level.
- `step` out `NCH`: step pulses, registered.
- `dir` out `NCH`: direction, registered, held after move.
- `busy` out `NCH`: channel executing a move.
- `done` out `NCH`: 1-cycle pulse on move completion or abort.
- `pos` out `NCH*POS_W`: signed positions; channel i at `[i*POS_W +: POS_W]`.

## Operation
- Per-channel FSM: IDLE → SETUP → HIGH ⇄ LOW → IDLE.
- `cmd_ready` = channel `cmd_ch` in IDLE and `abort[cmd_ch]`=0. It is combinational from state; there is no dependency on `cmd_valid`.
- On accept with steps>0: latch dir, steps, and effective period. Go to SETUP for `DIR_SETUP` cycles, then HIGH.
- Effective period = max(`cmd_period`, 2*`PULSE_CYCLES`). Compare at COUNT/PERIOD width with zero-extension.
- HIGH lasts `PULSE_CYCLES`. LOW lasts period−`PULSE_CYCLES`. On LOW end, if steps remain, go to HIGH.
- On HIGH exit for the last step: go to IDLE. There is no trailing LOW wait.
- Entry into HIGH: decrement remaining count; pos += 1 (dir=1) or −1 (dir=0). Two's-complement wrap at `POS_W`.
- steps=0 accepted: FSM stays IDLE. busy stays 0, done pulses next cycle, step/dir/pos unchanged.
- abort in SETUP or LOW: IDLE next cycle, done pulses.
- abort in HIGH: the pulse completes full `PULSE_CYCLES` (no runt), then IDLE with done. The step counts in pos.
- abort in IDLE: ignored. It only blocks `cmd_ready`.
- Channels are fully independent. Commands to other channels are accepted while one is busy.

## Timing
- Reset values: step=0, dir=0, busy=0, done=0, pos=0, all FSMs IDLE. Consequently `cmd_ready`=1 when abort=0.
- Accept at cycle t: dir and busy valid at t+1.
- First step rises at t+1+`DIR_SETUP`. Subsequent rises every effective period.
- Last step rises at r: step falls at r+`PULSE_CYCLES`. busy=0 and done=1 in that same cycle. `cmd_ready` for that channel is 1 from that cycle.
- pos updates in the same cycle step rises.
- Async reset mid-move: all outputs clear immediately. The move is discarded without a done pulse.

## Structure
- `rtmc_pkg` adds `step_state_e` (IDLE, SETUP, HIGH, LOW).
- Sub-module `rtmc_step_chan`: one channel FSM with its counters and position. `rtmc_step_gen` generates `NCH` instances, decodes `cmd_ch` to per-channel load strobes, and muxes `cmd_ready`.

## Test plan
Defaults: `PULSE_CYCLES`=4, `DIR_SETUP`=2.
- Reset: assert rst mid-simulation → step/busy/done/pos all 0 within the same cycle, `cmd_ready`=1.
- ch1, dir=1, steps=3, period=10 accepted at t=0 → step[1] high on cycles 3–6, 13–16, 23–26. pos[1]=1,2,3 at 3,13,23. done[1] at 27.
- period=5, steps=2 on ch0 at t=0 → clamped to 8. Rises at 3 and 11.
- steps=0 on ch2 → no step, busy[2] never 1, done[2] at t+1.
- abort[0] raised on the 2nd cycle of a HIGH → pulse still 4 cycles long, done[0] on fall, pos counted that step. dir=0 makes pos −1 per step, and −1 wraps from 0 correctly.
- ch0 busy and a cmd to ch0 presented → `cmd_ready`=0, command held off. Switching `cmd_ch`=3 in the same cycle → accepted, both channels step concurrently with correct independent timing.
